// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: one shared prescaler produces a base tick, and three
// channel counters turn it into ball, paddle and scan clock-enable strobes.
// Run/pause/stop control plus a valid/ready port for changing channel periods.
// Optional ball speed-up: define TICK_SPEEDUP_EN.
module game_tick_scheduler #(
  parameter int PRESCALE  = 12500,
  parameter int PW        = 12,
  parameter int BALL_P    = 40,
  parameter int PAD_P     = 20,
  parameter int SCAN_P    = 4,
  parameter int SPEEDUP_N = 8,
  parameter int BALL_MIN  = 10
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic          cmd_pause,
  input  logic          cmd_stop,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_sel,
  input  logic [PW-1:0] cfg_period,
  output logic          base_tick,
  output logic          tick_ball,
  output logic          tick_pad,
  output logic          tick_scan,
  output logic [1:0]    state
);

  localparam int PSW = $clog2(PRESCALE);
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } stateT;

  stateT          r_state;
  stateT          w_nextState;
  logic [PSW-1:0] r_presc;
  logic [PW-1:0]  r_period [3];
  logic [PW-1:0]  r_cnt [3];
  logic           r_pendValid;
  logic [1:0]     r_pendSel;
  logic [PW-1:0]  r_pendPeriod;
  logic           r_ready;
  logic           w_bt;
  logic           w_apply;
  logic           w_reloadAll;
  logic [2:0]     w_fire;

  // Channel index 0 is ball, 1 paddle, 2 scan.
  function automatic logic [PW-1:0] defaultPeriod(input int idx);
    case (idx)
      0:       return PW'(BALL_P);
      1:       return PW'(PAD_P);
      default: return PW'(SCAN_P);
    endcase
  endfunction

  // Next state: stop beats pause beats start; commands that make no sense in the current state are ignored.
  always_comb begin
    w_nextState = r_state;
    if (cmd_stop) begin
      w_nextState = ST_STOPPED;
    end else if (cmd_pause) begin
      if (r_state == ST_RUNNING) w_nextState = ST_PAUSED;
    end else if (cmd_start) begin
      if (r_state != ST_RUNNING) w_nextState = ST_RUNNING;
    end
  end

  // Event decode: base tick (killed by a coincident stop), pending-write apply and channel fire.
  always_comb begin
    w_bt        = (r_state == ST_RUNNING) && (r_presc == PRESC_LAST) && !cmd_stop;
    w_apply     = r_pendValid && !cmd_stop && ((r_state != ST_RUNNING) || w_bt);
    w_reloadAll = cmd_stop || ((r_state == ST_STOPPED) && cmd_start);
    for (int i = 0; i < 3; i++) begin
      w_fire[i] = w_bt && (r_period[i] != '0) && (r_cnt[i] == PW'(1));
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= ST_STOPPED;
    else     r_state <= w_nextState;
  end

  // Prescaler: counts while running, holds while paused, parked at zero when stopped.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (cmd_stop || (r_state == ST_STOPPED)) begin
      r_presc <= '0;
    end else if (r_state == ST_RUNNING) begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PSW'(1);
    end
  end

`ifdef TICK_SPEEDUP_EN
  localparam int SCW = (SPEEDUP_N > 1) ? $clog2(SPEEDUP_N) : 1;
  localparam logic [SCW-1:0] STROBE_LAST = SCW'(SPEEDUP_N - 1);

  logic [SCW-1:0] r_strobeCnt;
  logic           w_speedHit;

  assign w_speedHit = w_fire[0] && (r_strobeCnt == STROBE_LAST) && (r_period[0] > PW'(BALL_MIN));

  // Ball strobe counter; restarts on stop and whenever the ball period is written.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_strobeCnt <= '0;
    end else if (cmd_stop || (w_apply && (r_pendSel == 2'd0))) begin
      r_strobeCnt <= '0;
    end else if (w_fire[0]) begin
      r_strobeCnt <= (r_strobeCnt == STROBE_LAST) ? '0 : r_strobeCnt + SCW'(1);
    end
  end
`else
  logic w_speedHit;
  logic w_unusedSpeedupCfg;

  assign w_speedHit         = 1'b0;
  assign w_unusedSpeedupCfg = (SPEEDUP_N != 0) ^ (BALL_MIN != 0);
`endif

  // Periods and counters: a write sets both (restarting phase); the counter reloaded on fire uses the old period.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_period[i] <= defaultPeriod(i);
        r_cnt[i]    <= defaultPeriod(i);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_apply && (r_pendSel == 2'(i))) begin
          r_period[i] <= r_pendPeriod;
          r_cnt[i]    <= r_pendPeriod;
        end else begin
          if ((i == 0) && w_speedHit) r_period[i] <= r_period[i] - PW'(1);
          if (w_reloadAll) begin
            r_cnt[i] <= r_period[i];
          end else if (w_bt && (r_period[i] != '0)) begin
            r_cnt[i] <= (r_cnt[i] == PW'(1)) ? r_period[i] : r_cnt[i] - PW'(1);
          end
        end
      end
    end
  end

  // Config handshake: hold one pending write; ready returns once it has been applied (sel 3 is just dropped).
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_pendValid  <= 1'b0;
      r_pendSel    <= 2'd0;
      r_pendPeriod <= '0;
      r_ready      <= 1'b1;
    end else if (cfg_valid && r_ready) begin
      r_pendValid  <= 1'b1;
      r_pendSel    <= cfg_sel;
      r_pendPeriod <= cfg_period;
      r_ready      <= 1'b0;
    end else if (w_apply) begin
      r_pendValid  <= 1'b0;
      r_ready      <= 1'b1;
    end
  end

  // Registered strobes, one cycle after the base-tick event.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      base_tick <= 1'b0;
      tick_ball <= 1'b0;
      tick_pad  <= 1'b0;
      tick_scan <= 1'b0;
    end else begin
      base_tick <= w_bt;
      tick_ball <= w_fire[0];
      tick_pad  <= w_fire[1];
      tick_scan <= w_fire[2];
    end
  end

  assign state     = r_state;
  assign cfg_ready = r_ready;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed testbench for game_tick_scheduler with PRESCALE=4 and ball/pad/scan periods 3/2/1.
// Speed-up expectations follow TICK_SPEEDUP_EN.
module tb_game_tick_scheduler;

  localparam int PW = 12;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic          cmd_pause = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_sel = 2'd0;
  logic [PW-1:0] cfg_period = '0;
  logic          base_tick;
  logic          tick_ball;
  logic          tick_pad;
  logic          tick_scan;
  logic [1:0]    state;

  int checkCount = 0;
  int errorCount = 0;
  int strayCount = 0;

  game_tick_scheduler #(
    .PRESCALE(4), .PW(PW), .BALL_P(3), .PAD_P(2), .SCAN_P(1),
    .SPEEDUP_N(2), .BALL_MIN(10)
  ) dut (
    .clk_in(clk_in), .rst(rst),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_period(cfg_period),
    .base_tick(base_tick), .tick_ball(tick_ball), .tick_pad(tick_pad), .tick_scan(tick_scan),
    .state(state)
  );

  // Free-running board clock.
  always #5 clk_in = ~clk_in;

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; note any strobe seen without a base tick.
  task automatic tickClock();
    @(posedge clk_in);
    #1;
    if (!base_tick && (tick_ball || tick_pad || tick_scan)) strayCount++;
  endtask

  task automatic applyStimulus(input logic start, input logic pause, input logic stop);
    cmd_start = start;
    cmd_pause = pause;
    cmd_stop  = stop;
    tickClock();
    cmd_start = 1'b0;
    cmd_pause = 1'b0;
    cmd_stop  = 1'b0;
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [PW-1:0] per);
    cfg_valid  = 1'b1;
    cfg_sel    = sel;
    cfg_period = per;
    tickClock();
    cfg_valid  = 1'b0;
  endtask

  task automatic waitBaseTick(input int limit, output int steps);
    steps = 0;
    do begin
      tickClock();
      steps++;
    end while (!base_tick && steps < limit);
    checkOutput("baseTickSeen", base_tick, 1);
  endtask

  task automatic checkStrobes(input int n, input logic ball, input logic pad, input logic scan);
    checkOutput($sformatf("ball@bt%0d", n), tick_ball, ball);
    checkOutput($sformatf("pad@bt%0d", n), tick_pad, pad);
    checkOutput($sformatf("scan@bt%0d", n), tick_scan, scan);
  endtask

  initial begin
    int steps;
    int pulses;
    int gap;
    int expGap [8];
`ifdef TICK_SPEEDUP_EN
    expGap = '{12, 12, 12, 11, 11, 10, 10, 10};
`else
    expGap = '{12, 12, 12, 12, 12, 12, 12, 12};
`endif

    $display("[TB] reset state");
    tickClock();
    tickClock();
    checkOutput("rstState", state, 0);
    checkOutput("rstBaseTick", base_tick, 0);
    checkOutput("rstTicks", {tick_ball, tick_pad, tick_scan}, 0);
    checkOutput("rstReady", cfg_ready, 1);
    rst = 1'b0;
    tickClock();
    tickClock();
    checkOutput("stoppedIdle", {state, base_tick}, 0);

    $display("[TB] start and cadence");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("startState", state, 1);
    for (int n = 1; n <= 5; n++) begin
      waitBaseTick(8, steps);
      checkOutput($sformatf("btGap%0d", n), steps, 4);
      checkStrobes(n, (n % 3) == 0, (n % 2) == 0, 1'b1);
    end

    $display("[TB] pause and resume");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pauseState", state, 2);
    pulses = 0;
    repeat (20) begin
      tickClock();
      pulses += int'(base_tick | tick_ball | tick_pad | tick_scan);
    end
    checkOutput("pausePulses", pulses, 0);
    checkOutput("pauseHeld", state, 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resumeState", state, 1);
    waitBaseTick(8, steps);
    checkOutput("resumeGap", steps, 3);
    checkStrobes(6, 1'b1, 1'b1, 1'b1);

    $display("[TB] ball period write while running");
    cfgWrite(2'd0, PW'(5));
    checkOutput("readyLowAfterAccept", cfg_ready, 0);
    waitBaseTick(8, steps);
    checkOutput("applyGap", steps, 3);
    checkOutput("readyAfterApply", cfg_ready, 1);
    checkStrobes(7, 1'b0, 1'b0, 1'b1);
    for (int n = 8; n <= 12; n++) begin
      waitBaseTick(8, steps);
      checkStrobes(n, n == 12, (n % 2) == 0, 1'b1);
    end

    $display("[TB] paddle disable and discard write");
    cfgWrite(2'd1, PW'(0));
    checkOutput("padWriteReadyLow", cfg_ready, 0);
    waitBaseTick(8, steps);
    checkOutput("padWriteReadyBack", cfg_ready, 1);
    checkStrobes(13, 1'b0, 1'b0, 1'b1);
    cfgWrite(2'd3, PW'(7));
    checkOutput("discardReadyLow", cfg_ready, 0);
    waitBaseTick(8, steps);
    checkOutput("discardReadyBack", cfg_ready, 1);
    checkStrobes(14, 1'b0, 1'b0, 1'b1);
    for (int n = 15; n <= 17; n++) begin
      waitBaseTick(8, steps);
      checkStrobes(n, n == 17, 1'b0, 1'b1);
    end

    $display("[TB] stop on the base-tick cycle with a write");
    tickClock();
    tickClock();
    tickClock();
    checkOutput("preStopState", state, 1);
    cmd_stop   = 1'b1;
    cfg_valid  = 1'b1;
    cfg_sel    = 2'd0;
    cfg_period = PW'(2);
    tickClock();
    cmd_stop   = 1'b0;
    cfg_valid  = 1'b0;
    checkOutput("stopBaseTick", base_tick, 0);
    checkOutput("stopScan", tick_scan, 0);
    checkOutput("stopState", state, 0);
    checkOutput("stopReadyLow", cfg_ready, 0);
    tickClock();
    checkOutput("stopReadyBack", cfg_ready, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      waitBaseTick(8, steps);
      if (n == 1) checkOutput("restartGap", steps, 4);
      checkStrobes(n, (n % 2) == 0, 1'b0, 1'b1);
    end

    $display("[TB] asynchronous reset mid-run");
    #1;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstBaseTick", base_tick, 0);
    checkOutput("asyncRstTicks", {tick_ball, tick_pad, tick_scan}, 0);
    checkOutput("asyncRstState", state, 0);
    checkOutput("asyncRstReady", cfg_ready, 1);
    tickClock();
    rst = 1'b0;
    tickClock();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      waitBaseTick(8, steps);
      if (n == 1) checkOutput("postRstGap", steps, 4);
      checkStrobes(n, (n % 3) == 0, (n % 2) == 0, 1'b1);
    end

    $display("[TB] ball interval sequence with period 12");
    applyStimulus(1'b0, 1'b0, 1'b1);
    cfgWrite(2'd0, PW'(12));
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      gap = 0;
      do begin
        waitBaseTick(8, steps);
        gap++;
      end while (!tick_ball && gap < 20);
      checkOutput($sformatf("ballGap%0d", k), gap, expGap[k]);
    end

    checkOutput("strayStrobes", strayCount, 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Single shared prescaler producing a base tick from the board clock, scheduled into three per-channel enable strobes: ball motion, paddle motion and display scan.
- Sits between the board clock and the Pong game logic. Replaces ad-hoc per-module dividers with clock-enable strobes in one clock domain.
- Run/pause/stop state machine, plus a valid/ready handshake for reprogramming channel periods at runtime.

Parameters:
- PRESCALE, 12500, clk_in cycles per base tick (minimum 2).
- PW, 12, width of the channel period and counter registers.
- BALL_P, 40, reset period of the ball channel in base ticks.
- PAD_P, 20, reset period of the paddle channel in base ticks.
- SCAN_P, 4, reset period of the scan channel in base ticks.
- SPEEDUP_N, 8, ball strobes between speed-ups (optional feature only).
- BALL_MIN, 10, floor for the ball period (optional feature only).

Ports:
- clk_in  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle command: start or resume.
- cmd_pause  in  1  one-cycle command: pause.
- cmd_stop  in  1  one-cycle command: stop.
- cfg_valid  in  1  period write request.
- cfg_ready  out  1  scheduler can accept a period write.
- cfg_sel  in  2  target channel: 0 ball, 1 paddle, 2 scan, 3 discard.
- cfg_period  in  PW  new period in base ticks; 0 disables the channel.
- base_tick  out  1  one-cycle pulse per prescaler wrap.
- tick_ball  out  1  one-cycle ball strobe.
- tick_pad  out  1  one-cycle paddle strobe.
- tick_scan  out  1  one-cycle scan strobe.
- state  out  2  00 STOPPED, 01 RUNNING, 10 PAUSED.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=STOPPED; all tick outputs 0; cfg_ready=1.
  - Periods return to their *_P defaults; channel counters load their periods; prescaler=0; pending write cleared.
- FSM transitions. Command priority is stop > pause > start.
  - STOPPED + start -> RUNNING; counters reload from periods.
  - RUNNING + pause -> PAUSED.
  - PAUSED + start -> RUNNING; prescaler and counters resume from their held values.
  - Any state + stop -> STOPPED; prescaler cleared, counters reload.
  - All other command/state pairs are ignored.
- Prescaler:
  - Counts 0..PRESCALE-1 in RUNNING only; holds in PAUSED; held at 0 in STOPPED.
  - Internal event bt = RUNNING && count==PRESCALE-1; the count wraps to 0 on bt.
- Outputs: registered. base_tick asserts the cycle after bt. The first base_tick comes exactly PRESCALE cycles after the cycle in which start is sampled.
- Channel on bt:
  - period==0: no action.
  - cnt==1: strobe the following cycle (coincident with base_tick) and reload period.
  - Otherwise: cnt decrements.
  - Result: a channel with period P strobes on every P-th base_tick.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready; the write is latched as pending and cfg_ready drops the next cycle.
  - Pending write is applied on the next cycle in STOPPED or PAUSED, and on the next bt in RUNNING.
  - Apply writes the period and reloads that channel's counter, which restarts its phase.
  - cfg_ready returns high the cycle after apply. cfg_sel=3 is accepted and discarded.
- Simultaneous events:
  - Apply coincident with a channel's cnt==1: the strobe fires (old period), and the counter loads the new period.
  - stop coincident with bt: stop wins, so no base_tick or strobes are produced.
  - A pending write coincident with stop is applied in STOPPED the following cycle.
- Widths: counters are PW bits; the prescaler is ceil(log2(PRESCALE)) bits; no overflow is possible because counters only decrement toward 1.

Optional Feature:
- Macro: TICK_SPEEDUP_EN.
- Defined:
  - A ball strobe counter counts tick_ball.
  - Every SPEEDUP_N-th strobe, the ball period decrements by 1 if it is greater than BALL_MIN. The new value takes effect at the next reload.
  - The strobe counter clears on stop, on reset, and on any ball cfg apply; a cfg write sets the period exactly.
- Undefined: the ball period changes only via cfg writes; SPEEDUP_N and BALL_MIN are unused.

Test Plan:
- PRESCALE=4, ball/pad/scan periods=3/2/1, cmd_start -> base_tick every 4 cycles, first one 4 cycles after start; tick_scan on every base_tick, tick_pad on every 2nd, tick_ball on every 3rd.
- Pause after 5 base_ticks, hold 20 cycles, cmd_start -> no pulses while state=10. Phase preserved: next tick_ball on base_tick 6, and the first post-resume base_tick arrives exactly the remaining prescaler cycles after resume.
- RUNNING, write ball=5 mid-period -> cfg_ready low until the next bt; after apply, tick_ball on every 5th base_tick counting from the apply.
- Write pad=0 -> tick_pad never asserts; ball and scan cadence unchanged. Write cfg_sel=3 -> handshake completes with no period change.
- cmd_stop in the same cycle as bt, with cfg_valid high -> no strobes; state=00; write applied the next cycle. Assert rst mid-run -> outputs 0 immediately and defaults restored.
- With TICK_SPEEDUP_EN, ball=12, SPEEDUP_N=2, BALL_MIN=10 -> successive ball intervals 12,12,12,11,11,10,10,10... base ticks.
